// File: rtl/secded_stream_decoder_if.sv
// Stream bundle for the SECDED decoder: codeword in, corrected payload out.
// The master modport is the side that supplies codewords and consumes results.
interface secded_stream_decoder_if #(
    parameter int DATA_W = 11
);
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int P    = calc_p(DATA_W);
    localparam int CW_W = DATA_W + P + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [P:0]        out_pos;

    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_data, out_status, out_pos
    );

    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_data, out_status, out_pos
    );
endinterface

// File: rtl/secded_stream_decoder.sv
// Two-stage elastic Hamming SECDED decoder. Stage 1 captures the payload bits,
// the syndrome and the overall parity mismatch; stage 2 classifies, corrects and
// holds the registered result. Saturating single/double error counters for debug.
module secded_stream_decoder #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    secded_stream_decoder_if.slave io,
    input  logic                   cnt_clear,
    output logic [CNT_W-1:0]       single_cnt,
    output logic [CNT_W-1:0]       double_cnt
);
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    // Codeword position of payload bit idx (0-based): non-powers of two from 3 up.
    function automatic int dpos(input int idx);
        int pos;
        int n;
        pos = 2;
        n   = -1;
        while (n < idx) begin
            pos++;
            if ((pos & (pos - 1)) != 0) n++;
        end
        return pos;
    endfunction

    localparam int P    = calc_p(DATA_W);
    localparam int CW_W = DATA_W + P + 1;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_SINGLE = 2'b01;
    localparam logic [1:0] ST_DOUBLE = 2'b10;

    // Stage 1 keeps only the payload bits: parity bits carry no information
    // past the syndrome, and flipping one never changes the extracted data.
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_dat_q,   s1_dat_d;
    logic [P-1:0]      s1_syn_q,   s1_syn_d;
    logic              s1_par_q,   s1_par_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_status_q, out_status_d;
    logic [P:0]        out_pos_q,  out_pos_d;

    logic [CNT_W-1:0]  single_cnt_q, single_cnt_d;
    logic [CNT_W-1:0]  double_cnt_q, double_cnt_d;

    logic              s1_adv, in_ready_c, accept, xfer;
    logic              in_range;
    logic [DATA_W-1:0] data_x;
    logic [1:0]        status_x;
    logic [P:0]        pos_x;

    // Handshake: stage 1 may move on whenever stage 2 is empty or draining.
    always_comb begin
        s1_adv     = ~s2_valid_q | io.out_ready;
        in_ready_c = ~s1_valid_q | s1_adv;
        accept     = io.in_valid & in_ready_c;
        xfer       = s2_valid_q & io.out_ready;
    end

    // Stage 1: syndrome, overall mismatch and raw payload of the incoming codeword.
    always_comb begin
        s1_valid_d = in_ready_c ? io.in_valid : s1_valid_q;
        s1_dat_d   = s1_dat_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (accept) begin
            s1_syn_d = '0;
            for (int j = 1; j < CW_W; j++) begin
                if (io.in_cw[j]) s1_syn_d = s1_syn_d ^ P'(j);
            end
            for (int i = 0; i < DATA_W; i++) begin
                s1_dat_d[i] = io.in_cw[dpos(i)];
            end
            s1_par_d = ^io.in_cw;
        end
    end

    // Stage 2: classify, correct a single flipped payload bit, hold while stalled.
    always_comb begin
        in_range = (int'(s1_syn_q) < CW_W);
        data_x   = s1_dat_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (s1_par_q && in_range && (s1_syn_q == P'(dpos(i)))) data_x[i] = ~s1_dat_q[i];
        end
        status_x = ST_CLEAN;
        pos_x    = '0;
        if (!s1_par_q) begin
            if (s1_syn_q != '0) status_x = ST_DOUBLE;
        end else if (in_range) begin
            status_x = ST_SINGLE;
            pos_x    = {1'b0, s1_syn_q};
        end else begin
            status_x = ST_DOUBLE;
        end

        s2_valid_d   = s1_adv ? s1_valid_q : s2_valid_q;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        out_pos_d    = out_pos_q;
        if (s1_adv && s1_valid_q) begin
            out_data_d   = data_x;
            out_status_d = status_x;
            out_pos_d    = pos_x;
        end
    end

    // Error counters: count on transfer, saturate, clear wins over increment.
    always_comb begin
        single_cnt_d = single_cnt_q;
        double_cnt_d = double_cnt_q;
        if (cnt_clear) begin
            single_cnt_d = '0;
            double_cnt_d = '0;
        end else if (xfer) begin
            if (out_status_q == ST_SINGLE && single_cnt_q != '1) single_cnt_d = single_cnt_q + CNT_W'(1);
            if (out_status_q == ST_DOUBLE && double_cnt_q != '1) double_cnt_d = double_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset flushes both stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_dat_q     <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= ST_CLEAN;
            out_pos_q    <= '0;
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_dat_q     <= s1_dat_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s2_valid_q   <= s2_valid_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
            out_pos_q    <= out_pos_d;
            single_cnt_q <= single_cnt_d;
            double_cnt_q <= double_cnt_d;
        end
    end

    assign io.in_ready   = in_ready_c;
    assign io.out_valid  = s2_valid_q;
    assign io.out_data   = out_data_q;
    assign io.out_status = out_status_q;
    assign io.out_pos    = out_pos_q;
    assign single_cnt    = single_cnt_q;
    assign double_cnt    = double_cnt_q;
endmodule
